jtag_tap_param: RTL and testbench

// Parametrised, self-contained IEEE 1149.1 test access port: full 16-state TAP FSM, IR of IR_WIDTH bits,

---
 rtl/jtag_tap_if.sv | 33 +++
 rtl/jtag_tap_param.sv | 204 ++++++++++++++++++++
 tb/tb_jtag_tap_param.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_if.sv
// Pin-level and parallel-port bundle of the parametrised JTAG TAP.
// The board/bench drives it through the master view and the TAP drives it through the slave view.
interface jtag_tap_if #(
  parameter int unsigned IR_WIDTH = 4,
  parameter int unsigned BSR_LEN  = 10,
  parameter int unsigned USER_LEN = 8
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic [3:0]          state;
  logic [IR_WIDTH-1:0] IR_OUT;
  logic [BSR_LEN-1:0]  BSR_PI;
  logic [BSR_LEN-1:0]  BSR_PO;
  logic [USER_LEN-1:0] USER_CAPTURE;
  logic [USER_LEN-1:0] USER_PO;
  logic                USER_UPDATE;
  logic                EXTEST_ACTIVE;
  logic                INTEST_ACTIVE;

  modport master (
    output TMS, TDI, BSR_PI, USER_CAPTURE,
    input  TDO, TDO_EN, state, IR_OUT, BSR_PO, USER_PO, USER_UPDATE,
           EXTEST_ACTIVE, INTEST_ACTIVE
  );

  modport slave (
    input  TMS, TDI, BSR_PI, USER_CAPTURE,
    output TDO, TDO_EN, state, IR_OUT, BSR_PO, USER_PO, USER_UPDATE,
           EXTEST_ACTIVE, INTEST_ACTIVE
  );
endinterface

// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP: 16-state controller, instruction register/decode,
// BYPASS, IDCODE, boundary-scan and user data registers, registered TDO.
module jtag_tap_param #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5677,
  parameter int unsigned BSR_LEN    = 10,
  parameter int unsigned USER_LEN   = 8,
  parameter int unsigned OP_IDCODE  = 'h7,
  parameter int unsigned OP_SAMPLE  = 'h1,
  parameter int unsigned OP_EXTEST  = 'h2,
  parameter int unsigned OP_INTEST  = 'h3,
  parameter int unsigned OP_USER    = 'h8
) (
  input logic       TCK,
  input logic       TRST_N,
  jtag_tap_if.slave tap
);

  localparam int unsigned ID_LEN = 32;
  localparam logic [IR_WIDTH-1:0] OP_IDCODE_C = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE_C = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] OP_EXTEST_C = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] OP_INTEST_C = IR_WIDTH'(OP_INTEST);
  localparam logic [IR_WIDTH-1:0] OP_USER_C   = IR_WIDTH'(OP_USER);

  if (IR_WIDTH < 2) begin : g_ir_width_chk
    $error("jtag_tap_param: IR_WIDTH must be at least 2");
  end
  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_chk
    $error("jtag_tap_param: IDCODE_VAL bit 0 must be 1");
  end
  if (BSR_LEN < 1 || USER_LEN < 1) begin : g_len_chk
    $error("jtag_tap_param: BSR_LEN and USER_LEN must be at least 1");
  end

  typedef enum logic [3:0] {
    ST_EX2DR = 4'h0, ST_EX1DR = 4'h1, ST_SHDR  = 4'h2, ST_PDR   = 4'h3,
    ST_SELIR = 4'h4, ST_UPDR  = 4'h5, ST_CAPDR = 4'h6, ST_SELDR = 4'h7,
    ST_EX2IR = 4'h8, ST_EX1IR = 4'h9, ST_SHIR  = 4'hA, ST_PIR   = 4'hB,
    ST_RTI   = 4'hC, ST_UPIR  = 4'hD, ST_CAPIR = 4'hE, ST_TLR   = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYP, DR_ID, DR_BSR, DR_USER
  } dr_sel_e;

  tap_state_e          state_q, state_d;
  dr_sel_e             dr_sel;
  logic [IR_WIDTH-1:0] ir_sh_q, ir_sh_d;
  logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
  logic [ID_LEN-1:0]   id_q, id_d;
  logic                byp_q, byp_d;
  logic [BSR_LEN-1:0]  bsr_q, bsr_d;
  logic [BSR_LEN-1:0]  bsr_po_q, bsr_po_d;
  logic [USER_LEN-1:0] usr_q, usr_d;
  logic [USER_LEN-1:0] usr_po_q, usr_po_d;
  logic                usr_upd_q, usr_upd_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;

  // TAP controller state register
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) state_q <= ST_TLR;
    else         state_q <= state_d;
  end

  // Standard 1149.1 transitions on TMS
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:   state_d = tap.TMS ? ST_TLR   : ST_RTI;
      ST_RTI:   state_d = tap.TMS ? ST_SELDR : ST_RTI;
      ST_SELDR: state_d = tap.TMS ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: state_d = tap.TMS ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  state_d = tap.TMS ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: state_d = tap.TMS ? ST_UPDR  : ST_PDR;
      ST_PDR:   state_d = tap.TMS ? ST_EX2DR : ST_PDR;
      ST_EX2DR: state_d = tap.TMS ? ST_UPDR  : ST_SHDR;
      ST_UPDR:  state_d = tap.TMS ? ST_SELDR : ST_RTI;
      ST_SELIR: state_d = tap.TMS ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: state_d = tap.TMS ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  state_d = tap.TMS ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: state_d = tap.TMS ? ST_UPIR  : ST_PIR;
      ST_PIR:   state_d = tap.TMS ? ST_EX2IR : ST_PIR;
      ST_EX2IR: state_d = tap.TMS ? ST_UPIR  : ST_SHIR;
      ST_UPIR:  state_d = tap.TMS ? ST_SELDR : ST_RTI;
      default:  state_d = ST_TLR;
    endcase
  end

  // Data register selection from the latched instruction; undefined opcodes fall to bypass
  always_comb begin
    dr_sel = DR_BYP;
    if (ir_out_q == OP_IDCODE_C)
      dr_sel = DR_ID;
    else if (ir_out_q == OP_SAMPLE_C || ir_out_q == OP_EXTEST_C || ir_out_q == OP_INTEST_C)
      dr_sel = DR_BSR;
    else if (ir_out_q == OP_USER_C)
      dr_sel = DR_USER;
  end

  // Register actions keyed on the current TAP state
  always_comb begin
    ir_sh_d   = ir_sh_q;
    ir_out_d  = ir_out_q;
    id_d      = id_q;
    byp_d     = byp_q;
    bsr_d     = bsr_q;
    bsr_po_d  = bsr_po_q;
    usr_d     = usr_q;
    usr_po_d  = usr_po_q;
    usr_upd_d = 1'b0;
    tdo_d     = tdo_q;
    tdo_en_d  = (state_q == ST_SHDR) || (state_q == ST_SHIR);

    case (state_q)
      ST_CAPIR: ir_sh_d = IR_WIDTH'(2'b01);
      ST_SHIR: begin
        ir_sh_d = {tap.TDI, ir_sh_q[IR_WIDTH-1:1]};
        tdo_d   = ir_sh_q[0];
      end
      ST_UPIR: ir_out_d = ir_sh_q;
      ST_CAPDR: begin
        case (dr_sel)
          DR_ID:   id_d  = IDCODE_VAL;
          DR_BSR:  bsr_d = tap.BSR_PI;
          DR_USER: usr_d = tap.USER_CAPTURE;
          default: byp_d = 1'b0;
        endcase
      end
      ST_SHDR: begin
        case (dr_sel)
          DR_ID: begin
            id_d  = {tap.TDI, id_q[ID_LEN-1:1]};
            tdo_d = id_q[0];
          end
          DR_BSR: begin
            // Concatenate-and-shift form also covers single-bit registers
            bsr_d = BSR_LEN'({tap.TDI, bsr_q} >> 1);
            tdo_d = bsr_q[0];
          end
          DR_USER: begin
            usr_d = USER_LEN'({tap.TDI, usr_q} >> 1);
            tdo_d = usr_q[0];
          end
          default: begin
            byp_d = tap.TDI;
            tdo_d = byp_q;
          end
        endcase
      end
      ST_UPDR: begin
        if (dr_sel == DR_BSR) bsr_po_d = bsr_q;
        if (dr_sel == DR_USER) begin
          usr_po_d  = usr_q;
          usr_upd_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Instruction is already IDCODE on the first observable cycle of TLR
    if (state_q == ST_TLR || state_d == ST_TLR) ir_out_d = OP_IDCODE_C;
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_sh_q   <= '0;
      ir_out_q  <= OP_IDCODE_C;
      id_q      <= '0;
      byp_q     <= 1'b0;
      bsr_q     <= '0;
      bsr_po_q  <= '0;
      usr_q     <= '0;
      usr_po_q  <= '0;
      usr_upd_q <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_en_q  <= 1'b0;
    end else begin
      ir_sh_q   <= ir_sh_d;
      ir_out_q  <= ir_out_d;
      id_q      <= id_d;
      byp_q     <= byp_d;
      bsr_q     <= bsr_d;
      bsr_po_q  <= bsr_po_d;
      usr_q     <= usr_d;
      usr_po_q  <= usr_po_d;
      usr_upd_q <= usr_upd_d;
      tdo_q     <= tdo_d;
      tdo_en_q  <= tdo_en_d;
    end
  end

  assign tap.TDO           = tdo_q;
  assign tap.TDO_EN        = tdo_en_q;
  assign tap.state         = state_q;
  assign tap.IR_OUT        = ir_out_q;
  assign tap.BSR_PO        = bsr_po_q;
  assign tap.USER_PO       = usr_po_q;
  assign tap.USER_UPDATE   = usr_upd_q;
  assign tap.EXTEST_ACTIVE = (ir_out_q == OP_EXTEST_C);
  assign tap.INTEST_ACTIVE = (ir_out_q == OP_INTEST_C);

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: expected TDO bits are queued as TDI is driven
// and popped as each shift edge produces output.
module tb_jtag_tap_param;

  localparam int unsigned IRW  = 4;
  localparam int unsigned BSRL = 10;
  localparam int unsigned USRL = 8;

  logic TCK = 1'b0;
  logic TRST_N;
  int   n_pass = 0;
  int   n_total = 0;
  logic exp_q[$];

  jtag_tap_if #(.IR_WIDTH(IRW), .BSR_LEN(BSRL), .USER_LEN(USRL)) tap ();

  jtag_tap_param #(.IR_WIDTH(IRW), .BSR_LEN(BSRL), .USER_LEN(USRL)) dut (
    .TCK   (TCK),
    .TRST_N(TRST_N),
    .tap   (tap.slave)
  );

  always #5 TCK = ~TCK;

  // One TCK: drive TMS/TDI, then sample 1 time unit after the rising edge
  task automatic step(input logic tms, input logic tdi);
    tap.TMS = tms;
    tap.TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // RTI -> ShIR, shift value LSB first, UpIR -> RTI; captured pattern 0..01 must stream out
  task automatic load_ir(input logic [IRW-1:0] value);
    logic exp_bit;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < int'(IRW); i++) exp_q.push_back(i == 0);
    for (int i = 0; i < int'(IRW); i++) begin
      step(i == int'(IRW) - 1, value[i]);
      exp_bit = exp_q.pop_front();
      n_total++;
      if (tap.TDO !== exp_bit || tap.TDO_EN !== 1'b1)
        $display("FAIL ir_tdo bit%0d: got tdo=%b en=%b, want tdo=%b en=1", i, tap.TDO, tap.TDO_EN, exp_bit);
      else n_pass++;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_total++;
    if (tap.IR_OUT !== value)
      $display("FAIL ir_out: got %h, want %h", tap.IR_OUT, value);
    else n_pass++;
  endtask

  // RTI -> ShDR, shift n bits comparing TDO against the queue, stop in UpDR
  task automatic shift_dr(input logic [63:0] bits, input int n);
    logic exp_bit;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, bits[i]);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL dr_tdo bit%0d: got tdo=%b, want queued value (queue empty)", i, tap.TDO);
      end else begin
        exp_bit = exp_q.pop_front();
        if (tap.TDO !== exp_bit || tap.TDO_EN !== 1'b1)
          $display("FAIL dr_tdo bit%0d: got tdo=%b en=%b, want tdo=%b en=1", i, tap.TDO, tap.TDO_EN, exp_bit);
        else n_pass++;
      end
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    TRST_N = 1'b0;
    tap.TMS = 1'b1;
    tap.TDI = 1'b0;
    tap.BSR_PI = '0;
    tap.USER_CAPTURE = '0;
    repeat (2) @(posedge TCK);
    #1;
    n_total++;
    if (tap.state !== 4'hF || tap.IR_OUT !== 4'h7 || tap.TDO !== 1'b0 || tap.TDO_EN !== 1'b0 ||
        tap.BSR_PO !== '0 || tap.USER_PO !== '0 || tap.USER_UPDATE !== 1'b0)
      $display("FAIL reset_state: got st=%h ir=%h tdo=%b en=%b bpo=%h upo=%h upd=%b, want F 7 0 0 0 0 0",
               tap.state, tap.IR_OUT, tap.TDO, tap.TDO_EN, tap.BSR_PO, tap.USER_PO, tap.USER_UPDATE);
    else n_pass++;
    TRST_N = 1'b1;
    step(1'b1, 1'b0);
    n_total++;
    if (tap.state !== 4'hF) $display("FAIL tlr_hold: got %h, want f", tap.state);
    else n_pass++;
    step(1'b0, 1'b0);
    n_total++;
    if (tap.state !== 4'hC) $display("FAIL to_rti: got %h, want c", tap.state);
    else n_pass++;
  endtask

  task automatic test_idcode();
    logic [31:0] id = 32'h1234_5677;
    for (int i = 0; i < 32; i++) exp_q.push_back(id[i]);
    shift_dr(64'h0, 32);
    step(1'b0, 1'b0);
  endtask

  task automatic test_ir_extest();
    load_ir(4'h2);
    n_total++;
    if (tap.EXTEST_ACTIVE !== 1'b1 || tap.INTEST_ACTIVE !== 1'b0)
      $display("FAIL extest_flag: got ext=%b int=%b, want 1 0", tap.EXTEST_ACTIVE, tap.INTEST_ACTIVE);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [7:0] pat = 8'b1011_0011;
    logic [3:0] ops [2];
    ops[0] = 4'hF;
    ops[1] = 4'h5;
    for (int k = 0; k < 2; k++) begin
      load_ir(ops[k]);
      // Sequence left to right: bit7 of pat goes in first
      exp_q.push_back(1'b0);
      for (int i = 0; i < 7; i++) exp_q.push_back(pat[7 - i]);
      shift_dr({56'h0, pat[0], pat[1], pat[2], pat[3], pat[4], pat[5], pat[6], pat[7]}, 8);
      step(1'b0, 1'b0);
    end
  endtask

  task automatic test_user();
    logic [7:0] cap = 8'h3C;
    logic [7:0] din = 8'hA5;
    load_ir(4'h8);
    tap.USER_CAPTURE = cap;
    for (int i = 0; i < 8; i++) exp_q.push_back(cap[i]);
    shift_dr({56'h0, din}, 8);
    n_total++;
    if (tap.USER_UPDATE !== 1'b0) $display("FAIL upd_early: got %b, want 0", tap.USER_UPDATE);
    else n_pass++;
    step(1'b0, 1'b0);
    n_total++;
    if (tap.USER_PO !== din || tap.USER_UPDATE !== 1'b1)
      $display("FAIL user_update: got po=%h upd=%b, want po=%h upd=1", tap.USER_PO, tap.USER_UPDATE, din);
    else n_pass++;
    step(1'b0, 1'b0);
    n_total++;
    if (tap.USER_UPDATE !== 1'b0 || tap.USER_PO !== din)
      $display("FAIL user_pulse_end: got po=%h upd=%b, want po=%h upd=0", tap.USER_PO, tap.USER_UPDATE, din);
    else n_pass++;
  endtask

  task automatic test_bsr();
    logic [9:0] cap = 10'h2AA;
    logic [9:0] din = 10'h155;
    load_ir(4'h1);
    tap.BSR_PI = cap;
    for (int i = 0; i < 10; i++) exp_q.push_back(cap[i]);
    shift_dr({54'h0, din}, 10);
    n_total++;
    if (tap.BSR_PO !== '0) $display("FAIL bsr_po_early: got %h, want 000", tap.BSR_PO);
    else n_pass++;
    step(1'b0, 1'b0);
    n_total++;
    if (tap.BSR_PO !== din || tap.USER_UPDATE !== 1'b0)
      $display("FAIL bsr_update: got po=%h upd=%b, want po=%h upd=0", tap.BSR_PO, tap.USER_UPDATE, din);
    else n_pass++;
  endtask

  task automatic test_tms_reset();
    logic [7:0] paths [16];
    int         plen  [16];
    logic [3:0] codes [16];
    codes = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    // TMS sequences from RTI, bit i applied at step i
    paths = '{8'b111, 8'b0, 8'b1, 8'b01, 8'b001, 8'b101, 8'b0101, 8'b10101,
              8'b1101, 8'b11, 8'b011, 8'b0011, 8'b1011, 8'b01011, 8'b101011, 8'b11011};
    plen  = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
    for (int s = 0; s < 16; s++) begin
      load_ir(4'h3);
      for (int i = 0; i < plen[s]; i++) step(paths[s][i], 1'b0);
      n_total++;
      if (tap.state !== codes[s]) $display("FAIL walk_%h: got %h, want %h", codes[s], tap.state, codes[s]);
      else n_pass++;
      repeat (5) step(1'b1, 1'b0);
      n_total++;
      if (tap.state !== 4'hF || tap.IR_OUT !== 4'h7)
        $display("FAIL tms5_from_%h: got st=%h ir=%h, want f 7", codes[s], tap.state, tap.IR_OUT);
      else n_pass++;
      step(1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    load_ir(4'h8);
    tap.USER_CAPTURE = 8'hFF;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #2;
    TRST_N = 1'b0;
    #1;
    n_total++;
    if (tap.state !== 4'hF || tap.IR_OUT !== 4'h7 || tap.TDO !== 1'b0 ||
        tap.BSR_PO !== '0 || tap.USER_PO !== '0 || tap.TDO_EN !== 1'b0)
      $display("FAIL async_reset: got st=%h ir=%h tdo=%b en=%b bpo=%h upo=%h, want F 7 0 0 0 0",
               tap.state, tap.IR_OUT, tap.TDO, tap.TDO_EN, tap.BSR_PO, tap.USER_PO);
    else n_pass++;
    @(posedge TCK);
    #1;
    TRST_N = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_extest();
    test_bypass();
    test_user();
    test_bsr();
    test_tms_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
